mac_result_fifo: RTL and testbench
==================================

# mac_result_fifo

Downstream capture stage for the 14x14 saturating multiply-accumulate unit. Accepts each accumulator value the MAC presents on its `valid_out` strobe, tags values that sit at a saturation rail, and buffers them in a small circular FIFO drained through a ready/valid handshake. The MAC cannot be stalled, so this block never backpressures it. When the FIFO is full, it drops incoming results and records the loss in sticky status.

## Interface
- `WIDTH`, 28: accumulator width in bits; matches the MAC `f` output.
- `DEPTH`, 8: number of FIFO entries; must be a power of two, minimum 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: reset, synchronous, active-high.
- `f_in`  in  WIDTH: signed accumulator value from the MAC.
- `f_valid`  in  1: push strobe from MAC `valid_out`; one result per high cycle.
- `out_data`  out  WIDTH: head-of-FIFO value.
- `out_sat`  out  1: head value equals a saturation rail.
- `out_valid`  out  1: head entry present.
- `out_ready`  in  1: consumer accepts the head this cycle.
- `count`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow`  out  1: sticky flag; at least one result was dropped since reset.
- `drop_count`  out  8: number of dropped results, saturating at 255.

## Operation
- Storage: DEPTH entries of WIDTH+1 bits, holding {sat, value}. Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Sat tag: the stored sat bit is 1 when `f_in` equals 28'h7FFFFFF (MAX) or 28'h8000000 (MIN). For other WIDTH values, the rails are the signed max and signed min for that width.
- Push condition: `f_valid` is high and, in the same cycle, either the FIFO is not full or a pop is occurring.
- Pop condition: `out_valid && out_ready`.
- `out_valid` = (`count` != 0). `out_data` and `out_sat` are taken from the entry at the read pointer.
- Push and pop in the same cycle: both occur and `count` is unchanged. This holds at full and at any nonzero occupancy.
- Empty with push: the value is written and `out_valid` rises on the next cycle. There is no combinational fall-through.
- Full with push and no pop: the value is discarded, no pointer moves, `overflow` is set to 1, and `drop_count` increments unless it already holds 255.
- `out_ready` while empty: ignored; no pointer or count change.
- When `out_valid` is low, `out_data` and `out_sat` are don't-care. The bench must not check them in that state.
- `overflow` and `drop_count` are cleared only by `reset`.

## Timing
- Reset (any cycle, including mid-stream): on the next edge, pointers = 0, `count` = 0, `out_valid` = 0, `overflow` = 0, `drop_count` = 0. Storage contents are not cleared. A push or pop in the reset cycle is ignored.
- Push latency: an `f_valid` sampled at edge N makes the value visible at the head, when it is the oldest entry, after edge N. `out_valid` is high in cycle N+1.
- Pop: the head advances on the edge where the pop condition holds. The next entry, or `out_valid` = 0, appears in the following cycle.
- `count`, `overflow` and `drop_count` are registered and reflect all events up to the last edge.
- Throughput: one push and one pop per cycle, sustained.
- Ordering: results leave in the order they were pushed. Dropped results leave no gap and no marker.

## Test plan
- Reset, then push 5, -3, 1000 on consecutive cycles with `out_ready` = 0. Then `count` = 3, `out_valid` = 1, and `out_data` = 5. Raise `out_ready` for 3 cycles: the outputs are 5, -3, 1000 in order, then `out_valid` = 0 and `count` = 0.
- Push 28'h7FFFFFF, 28'h8000000, then 28'h7FFFFFE. The `out_sat` sequence is 1, 1, 0.
- With `out_ready` = 0, push 10 values (1..10) into the DEPTH=8 FIFO. Then `count` = 8, `overflow` = 1, `drop_count` = 2. Drain: the outputs are 1..8 only.
- At full, hold `f_valid` and `out_ready` high for 4 cycles with values 100..103. Then `count` stays 8, `drop_count` does not change, and after draining, the last 4 outputs are 100..103.
- Push and pop on every cycle for 20 cycles, crossing pointer wrap. The outputs equal the inputs delayed by one cycle and `count` never exceeds 1.
- Push 3 values, assert `reset` for one cycle while `out_ready` = 1. Then `count` = 0, `out_valid` = 0, `overflow` = 0. A following push of 7 appears as `out_data` = 7.

Source files
------------

// File: rtl/mac_result_fifo_if.sv
// mac_result_fifo_if
// Bundles the push side (MAC results), the pop side (ready/valid drain) and
// the occupancy/loss status of the MAC result FIFO.
//   master : the environment; drives f_in/f_valid/out_ready, observes the rest
//   slave  : the FIFO itself
// Signals:
//   f_in, f_valid          accumulator value and its push strobe
//   out_data, out_sat      head-of-FIFO value and its saturation tag
//   out_valid, out_ready   drain handshake
//   count                  occupancy 0..DEPTH
//   overflow, drop_count   sticky loss flag and saturating drop counter
interface mac_result_fifo_if #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8
);
  logic [WIDTH-1:0]         f_in;
  logic                     f_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_sat;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic [7:0]               drop_count;

  modport master (
    output f_in, f_valid, out_ready,
    input  out_data, out_sat, out_valid, count, overflow, drop_count
  );

  modport slave (
    input  f_in, f_valid, out_ready,
    output out_data, out_sat, out_valid, count, overflow, drop_count
  );
endinterface

// File: rtl/mac_result_fifo.sv
// mac_result_fifo
// Capture stage behind the saturating MAC. Every f_valid result is stored with
// a tag saying whether it sits on a saturation rail. The MAC cannot be
// stalled, so nothing here pushes back on it: when the FIFO is full and no pop
// frees a slot, the result is dropped and the loss is counted.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    mac_result_fifo_if.slave (push, drain handshake, status)
module mac_result_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  mac_result_fifo_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Each entry is {sat, value}.
  logic [WIDTH:0]  mem_q [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_count_q, drop_count_d;

  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic            sat_in;

  assign full   = (count_q == CW'(DEPTH));
  assign pop    = (count_q != '0) && bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push   = bus.f_valid && (!full || pop);
  assign drop   = bus.f_valid && full && !pop;
  assign sat_in = (bus.f_in == SAT_MAX) || (bus.f_in == SAT_MIN);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count_q, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= {sat_in, bus.f_in};
  end

  assign bus.out_data   = mem_q[rd_ptr_q][WIDTH-1:0];
  assign bus.out_sat    = mem_q[rd_ptr_q][WIDTH];
  assign bus.out_valid  = (count_q != '0);
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;
endmodule

// File: tb/tb_mac_result_fifo.sv
module tb_mac_result_fifo;
  localparam int WIDTH = 28;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mac_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  mac_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of {sat, value} plus loss bookkeeping.
  logic [WIDTH:0] mq [$];
  int             m_drops;
  bit             m_ovf;
  bit             model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_drops  = 0;
      m_ovf    = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      bit do_pop;
      bit fits;
      do_pop = (mq.size() != 0) && (bus.out_ready === 1'b1);
      fits   = (mq.size() < DEPTH) || do_pop;
      if (do_pop) void'(mq.pop_front());
      if (bus.f_valid === 1'b1) begin
        if (fits) begin
          mq.push_back({(bus.f_in == 28'h7FFFFFF) || (bus.f_in == 28'h8000000), bus.f_in});
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("cmp_count", 32'(bus.count), 32'(mq.size()));
      check("cmp_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      check("cmp_overflow", 32'(bus.overflow), 32'(m_ovf));
      check("cmp_drops", 32'(bus.drop_count), 32'(m_drops));
      if (mq.size() != 0) begin
        check("cmp_data", 32'(bus.out_data), 32'(mq[0][WIDTH-1:0]));
        check("cmp_sat", 32'(bus.out_sat), 32'(mq[0][WIDTH]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
    bus.f_valid   = v;
    bus.f_in      = d;
    bus.out_ready = r;
  endtask

  logic [WIDTH-1:0] last4 [4];

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_drops", 32'(bus.drop_count), 32'd0);
    reset = 1'b0;

    // Ordered push then drain.
    drive(1'b1, 28'd5, 1'b0);         tick();
    drive(1'b1, 28'hFFFFFFD, 1'b0);   tick();
    drive(1'b1, 28'd1000, 1'b0);      tick();
    drive(1'b0, '0, 1'b0);
    check("t1_count", 32'(bus.count), 32'd3);
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_head", 32'(bus.out_data), 32'd5);
    drive(1'b0, '0, 1'b1);
    check("t1_pop0", 32'(bus.out_data), 32'd5);          tick();
    check("t1_pop1", 32'(bus.out_data), 32'h0FFFFFFD);   tick();
    check("t1_pop2", 32'(bus.out_data), 32'd1000);       tick();
    check("t1_empty_valid", 32'(bus.out_valid), 32'd0);
    check("t1_empty_count", 32'(bus.count), 32'd0);

    // Saturation tagging: both rails and one value just inside.
    drive(1'b1, 28'h7FFFFFF, 1'b0); tick();
    drive(1'b1, 28'h8000000, 1'b0); tick();
    drive(1'b1, 28'h7FFFFFE, 1'b0); tick();
    drive(1'b0, '0, 1'b1);
    check("t2_sat0", 32'(bus.out_sat), 32'd1); tick();
    check("t2_sat1", 32'(bus.out_sat), 32'd1); tick();
    check("t2_sat2", 32'(bus.out_sat), 32'd0); tick();
    drive(1'b0, '0, 1'b0);

    // Overfill: 10 pushes into 8 slots.
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("t3_count", 32'(bus.count), 32'd8);
    check("t3_overflow", 32'(bus.overflow), 32'd1);
    check("t3_drops", 32'(bus.drop_count), 32'd2);
    drive(1'b0, '0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      check("t3_drain", 32'(bus.out_data), 32'(i));
      tick();
    end
    check("t3_drained", 32'(bus.out_valid), 32'd0);

    // At full, simultaneous push and pop must not drop.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, WIDTH'(50 + i), 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, WIDTH'(100 + i), 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("t4_count", 32'(bus.count), 32'd8);
    check("t4_drops", 32'(bus.drop_count), 32'd2);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i >= 4) last4[i-4] = bus.out_data;
      tick();
    end
    for (int i = 0; i < 4; i++) check("t4_tail", 32'(last4[i]), 32'(100 + i));
    check("t4_drained", 32'(bus.out_valid), 32'd0);

    // Streaming push+pop every cycle across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, WIDTH'(300 + i), 1'b1);
      if (i > 0) check("t5_delay1", 32'(bus.out_data), 32'(300 + i - 1));
      check("t5_cnt_le1", 32'(bus.count <= 1), 32'd1);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    check("t5_last", 32'(bus.out_data), 32'd319);
    tick();
    check("t5_empty", 32'(bus.out_valid), 32'd0);

    // Mid-stream reset with out_ready high.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, WIDTH'(40 + i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_count", 32'(bus.count), 32'd0);
    check("t6_valid", 32'(bus.out_valid), 32'd0);
    check("t6_overflow", 32'(bus.overflow), 32'd0);
    check("t6_drops", 32'(bus.drop_count), 32'd0);
    drive(1'b1, 28'd7, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    check("t6_valid_after", 32'(bus.out_valid), 32'd1);
    check("t6_data", 32'(bus.out_data), 32'd7);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
